// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared constants and types for the instruction fetch stage.
//   XLEN             : datapath / address width
//   NOP_INSTR        : encoding presented on out_instr while the buffer is empty
//   ALIGN_MASK       : clears the two low address bits of a fetch target
//   RESET_PC_DEFAULT : default byte address fetched first after reset
//   fetch_entry_t    : one fetch buffer entry {pc, instr}
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MASK       = ~32'h0000_0003;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto an instruction word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small FIFO of fetched {pc, instr} entries with a registered head.
//   clk_i        : clock, all state on rising edge
//   rst_i        : synchronous active-high reset (highest priority)
//   flush_i      : drop every entry; empty on the next cycle
//   push_i       : enqueue push_entry_i (caller guarantees room or a pop)
//   pop_i        : dequeue the head (caller guarantees non-empty)
//   push_entry_i : entry to enqueue
//   head_o       : registered head entry; instr=NOP when empty, pc holds
//   count_o      : current occupancy
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     Depth   = 2,
    parameter logic [XLEN-1:0] ResetPc = RESET_PC_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  fetch_entry_t               push_entry_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    fetch_entry_t    head_q, head_d;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;

        if (flush_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            // pc field keeps the last head value
            head_d.instr = NOP_INSTR;
        end else begin
            if (push_i) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end

            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase

            // The next head is the slot rd_ptr_d points at. If that slot is
            // being written this very cycle, bypass the incoming entry since
            // the array still holds stale contents there.
            if (count_d == '0) begin
                head_d.instr = NOP_INSTR;
            end else if (push_i && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_entry_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q.pc    <= ResetPc;
            head_q.instr <= NOP_INSTR;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, reads a combinational instruction
// memory every cycle, buffers {pc, instr} in fetch_fifo and hands entries to
// decode over valid/ready. Execute redirects flush all in-flight entries.
//   clk             : clock
//   reset           : synchronous active-high reset
//   imem_addr       : byte address to instruction memory (= pc register)
//   imem_data       : instruction word for imem_addr, same cycle
//   redirect_valid  : execute redirect request
//   redirect_target : new fetch address, low two bits ignored
//   out_valid       : head entry valid
//   out_ready       : decode accepts head this cycle
//   out_instr       : head instruction (NOP when empty)
//   out_pc          : head PC (last head value when empty)
//   buf_count       : buffer occupancy
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [31:0]                    imem_addr,
    input  logic [31:0]                    imem_data,
    input  logic                           redirect_valid,
    input  logic [31:0]                    redirect_target,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_instr,
    output logic [31:0]                    out_pc,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);

    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

    if (BUF_DEPTH < 2 || BUF_DEPTH > 8) begin : g_bad_depth
        $error("fetch_unit: BUF_DEPTH must be in 2..8");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_unit: RESET_PC must be word aligned");
    end

    logic [31:0]     pc_q, pc_d;
    logic            push, pop, full;
    logic [CntW-1:0] count;
    fetch_entry_t    push_entry, head;

    assign full      = (count == CntW'(BUF_DEPTH));
    assign out_valid = (count != '0);

    // A redirect squashes both the pending pop and this cycle's fetch.
    assign pop  = out_valid & out_ready & ~redirect_valid;
    // A full buffer can still take a fetch when the head leaves this cycle.
    assign push = ~reset & ~redirect_valid & (~full | pop);

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = imem_data;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_target);
        end else if (push) begin
            pc_d = pc_q + PC_STEP;  // wraps modulo 2^32
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .Depth   (BUF_DEPTH),
        .ResetPc (RESET_PC)
    ) u_fifo (
        .clk_i        (clk),
        .rst_i        (reset),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .pop_i        (pop),
        .push_entry_i (push_entry),
        .head_o       (head),
        .count_o      (count)
    );

    assign imem_addr = pc_q;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign buf_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  buf_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory model: word for an address is the address XOR a fixed key.
    assign imem_data = imem_addr ^ KEY;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2),
        .PC_STEP   (32'd4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .buf_count       (buf_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Head entry check: valid, pc, and instruction from the memory model.
    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".instr"}, out_instr, pc ^ KEY);
    endtask

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        out_ready       = 1'b0;
        step();
        step();

        // Reset state
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.count", {30'd0, buf_count}, 32'd0);
        chk("rst.instr", out_instr, NOP);
        chk("rst.pc", out_pc, 32'h0);
        chk("rst.addr", imem_addr, 32'h0);

        // Streaming: one entry per cycle starting the first cycle after reset
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_head($sformatf("stream%0d", k), 32'(4 * k));
            chk($sformatf("stream%0d.addr", k), imem_addr, 32'(4 * k + 4));
            chk($sformatf("stream%0d.count", k), {30'd0, buf_count}, 32'd1);
        end

        // Mid-stream reset, then stall from reset
        reset = 1'b1;
        step();
        chk("rst2.valid", {31'd0, out_valid}, 32'd0);
        chk("rst2.addr", imem_addr, 32'h0);
        reset     = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 4) chk("stall.mid.pc", out_pc, 32'h0);
        end
        chk("stall.count", {30'd0, buf_count}, 32'd2);
        chk("stall.addr", imem_addr, 32'h8);
        chk_head("stall.head", 32'h0);

        // Release: 0 consumed, then 4 and 8 appear in order
        out_ready = 1'b1;
        step();
        chk_head("rel1", 32'h4);
        chk("rel1.count", {30'd0, buf_count}, 32'd2);
        chk("rel1.addr", imem_addr, 32'hC);
        step();
        chk_head("rel2", 32'h8);
        out_ready = 1'b0;  // buffer now holds {8, 12}

        // Redirect with two entries buffered
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        chk("redir.count", {30'd0, buf_count}, 32'd0);
        chk("redir.valid", {31'd0, out_valid}, 32'd0);
        chk("redir.addr", imem_addr, 32'h100);
        chk("redir.instr", out_instr, NOP);
        chk("redir.pc_hold", out_pc, 32'h8);
        step();
        chk_head("redir.tgt", 32'h100);
        chk("redir.tgt.addr", imem_addr, 32'h104);

        // Redirect coincident with a valid handshake: head not consumed
        out_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        chk("redir2.count", {30'd0, buf_count}, 32'd0);
        chk("redir2.addr", imem_addr, 32'h200);
        step();
        chk_head("redir2.tgt", 32'h200);
        step();
        chk_head("redir2.next", 32'h204);

        // Redirect near the top of the address space: PC wraps
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk_head("wrap0", 32'hFFFF_FFFC);
        chk("wrap0.addr", imem_addr, 32'h0);
        step();
        chk_head("wrap1", 32'h0);
        step();
        chk_head("wrap2", 32'h4);

        // Fill the buffer, then reset for one cycle
        out_ready = 1'b0;
        step();
        step();
        chk("full.count", {30'd0, buf_count}, 32'd2);
        chk("full.addr", imem_addr, 32'hC);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst3.valid", {31'd0, out_valid}, 32'd0);
        chk("rst3.count", {30'd0, buf_count}, 32'd0);
        chk("rst3.instr", out_instr, NOP);
        chk("rst3.addr", imem_addr, 32'h0);
        out_ready = 1'b1;
        step();
        chk_head("resume0", 32'h0);
        step();
        chk_head("resume1", 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
